// File: rtl/fifo_param_umbral_pkg.sv
// Package for fifo_param_umbral: default geometry and reset value taken from
// fifo_defs.vh, plus the sticky-flag update helper shared by both error flags.
// No ports; imported by the top, the interface users and the bench.
`include "fifo_defs.vh"

package fifo_param_umbral_pkg;

  localparam int DATA_WIDTH_DEF = `FIFO_DATA_WIDTH;
  localparam int ADDR_WIDTH_DEF = `FIFO_ADDR_WIDTH;
  localparam int DOUT_RST_DEF   = `FIFO_DOUT_RST;

  // A new event wins over a clear arriving in the same cycle.
  function automatic logic sticky_next(input logic cur, input logic evt, input logic clr);
    return evt | (cur & ~clr);
  endfunction

endpackage

// File: rtl/fifo_param_umbral_if.sv
// Bus between a FIFO user (master) and fifo_param_umbral (slave).
// master drives write/read requests, clear_error, data_in and the two thresholds;
// slave returns read data, valid_out, occupancy flags, error flags and count.
interface fifo_param_umbral_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
);
  logic                  write_enable;
  logic                  read_enable;
  logic                  clear_error;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH:0]   umbral_bajo;
  logic [ADDR_WIDTH:0]   umbral_alto;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic                  error;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output write_enable, read_enable, clear_error, data_in, umbral_bajo, umbral_alto,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
    input  overflow, underflow, error, count
  );

  modport slave (
    input  write_enable, read_enable, clear_error, data_in, umbral_bajo, umbral_alto,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
    output overflow, underflow, error, count
  );
endinterface

// File: rtl/fifo_defs.vh
// Shared defaults for the fifo_param_umbral block: word width, address width
// (depth = 2**ADDR_WIDTH) and the value data_out takes while in reset.
// Guarded so it can be pulled in from several compilation units.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DATA_WIDTH 12
`define FIFO_ADDR_WIDTH 3
`define FIFO_DOUT_RST   0

`endif

// File: rtl/fifo_param_umbral_memoria_dp.sv
// memoria_dp: dual-port RAM, one synchronous write port, one registered read port.
// Ports: clk, reset (async active-low, clears only the read register),
//        wr_en/wr_addr/wr_data, rd_en/rd_addr/rd_data (rd_data holds when rd_en low).
module memoria_dp #(
  parameter int                    DATA_WIDTH = 12,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-during-write to the same address returns the old word, which is
  // what a simultaneous read/write on a full FIFO needs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= RST_VAL;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fifo_param_umbral.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds and
// sticky overflow/underflow flags. Ports: clk, reset (async active-low), bus (slave).
// Read data is registered (one-cycle latency, valid_out marks it); storage lives in memoria_dp.
module fifo_param_umbral
  import fifo_param_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  fifo_param_umbral_if.slave bus
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [DATA_WIDTH-1:0] DOUT_RST  = DATA_WIDTH'(DOUT_RST_DEF);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  valid_q, overflow_q, underflow_q;
  logic                  full_c, empty_c;
  logic                  wr_acc, rd_acc, ovf_evt, unf_evt;
  logic [DATA_WIDTH-1:0] rd_data;

  assign full_c  = (count == DEPTH_CNT);
  assign empty_c = (count == '0);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_acc  = bus.read_enable & ~empty_c;
  assign wr_acc  = bus.write_enable & (~full_c | rd_acc);
  assign ovf_evt = bus.write_enable & full_c & ~rd_acc;
  assign unf_evt = bus.read_enable & empty_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Accept rules keep count inside 0..DEPTH without extra saturation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      valid_q     <= rd_acc;
      overflow_q  <= sticky_next(overflow_q, ovf_evt, bus.clear_error);
      underflow_q <= sticky_next(underflow_q, unf_evt, bus.clear_error);
    end
  end

  memoria_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RST_VAL    (DOUT_RST)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.data_out     = rd_data;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count >= bus.umbral_alto);
  assign bus.almost_empty = (count <= bus.umbral_bajo);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.error        = overflow_q | underflow_q;
endmodule

// File: tb/tb_fifo_param_umbral.sv
// Directed bench for fifo_param_umbral: a vector table covering fill/drain,
// overflow, simultaneous access at full, underflow and error clearing, then
// hand sequences for mid-cycle async reset and pointer wrap.
module tb_fifo_param_umbral;
  import fifo_param_umbral_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int AW = ADDR_WIDTH_DEF;
  localparam int DEPTH = 1 << AW;
  localparam int UB = 2;
  localparam int UA = 6;

  typedef struct {
    logic          we, re, clr;
    logic [DW-1:0] din;
    int            cnt;
    logic          vld;
    logic [DW-1:0] dout;
    logic          ovf, unf;
  } vec_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  fifo_param_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_param_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic re, input logic clr,
                              input logic [DW-1:0] din, input int cnt, input logic vld,
                              input logic [DW-1:0] dout, input logic ovf, input logic unf);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.din = din; v.cnt = cnt;
    v.vld = vld; v.dout = dout; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags are derived from the expected occupancy with fixed thresholds UB/UA.
  task automatic check_all(input string tag, input int cnt, input logic vld,
                           input logic [DW-1:0] dout, input logic ovf, input logic unf);
    check({tag, ".count"},        32'(bus.count),        32'(cnt));
    check({tag, ".full"},         32'(bus.full),         32'(cnt == DEPTH));
    check({tag, ".empty"},        32'(bus.empty),        32'(cnt == 0));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(cnt >= UA));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= UB));
    check({tag, ".valid_out"},    32'(bus.valid_out),    32'(vld));
    check({tag, ".data_out"},     32'(bus.data_out),     32'(dout));
    check({tag, ".overflow"},     32'(bus.overflow),     32'(ovf));
    check({tag, ".underflow"},    32'(bus.underflow),    32'(unf));
    check({tag, ".error"},        32'(bus.error),        32'(ovf | unf));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic drive(input logic we, input logic re, input logic clr, input logic [DW-1:0] din);
    @(negedge clk);
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.clear_error  = clr;
    bus.data_in      = din;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[25];

  initial begin
    logic [DW-1:0] rst_dout;
    rst_dout = DW'(DOUT_RST_DEF);

    // Vector table: from reset, fill, overflow, full read+write, clear, drain,
    // underflow with write, underflow held against a coincident clear, clear.
    for (int i = 0; i < DEPTH; i++)
      vt[i] = mk(1, 0, 0, DW'(i + 1), i + 1, 0, rst_dout, 0, 0);
    vt[8]  = mk(1, 0, 0, 12'hABC, 8, 0, rst_dout, 1, 0);
    vt[9]  = mk(1, 1, 0, 12'h0FF, 8, 1, 12'h001, 1, 0);
    vt[10] = mk(0, 0, 1, 12'h000, 8, 0, 12'h001, 0, 0);
    for (int k = 0; k < 7; k++)
      vt[11 + k] = mk(0, 1, 0, 12'h000, 7 - k, 1, DW'(k + 2), 0, 0);
    vt[18] = mk(0, 1, 0, 12'h000, 0, 1, 12'h0FF, 0, 0);
    vt[19] = mk(1, 1, 0, 12'h055, 1, 0, 12'h0FF, 0, 1);
    vt[20] = mk(0, 1, 0, 12'h000, 0, 1, 12'h055, 0, 1);
    vt[21] = mk(0, 1, 0, 12'h000, 0, 0, 12'h055, 0, 1);
    vt[22] = mk(0, 1, 1, 12'h000, 0, 0, 12'h055, 0, 1);
    vt[23] = mk(0, 0, 1, 12'h000, 0, 0, 12'h055, 0, 0);
    vt[24] = mk(0, 0, 0, 12'h000, 0, 0, 12'h055, 0, 0);

    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.clear_error  = 1'b0;
    bus.data_in      = '0;
    bus.umbral_bajo  = (AW+1)'(UB);
    bus.umbral_alto  = (AW+1)'(UA);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, rst_dout, 0, 0);

    // Release on a falling edge so the first write lands on the next rising edge.
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(vt[i].we, vt[i].re, vt[i].clr, vt[i].din);
      check_all($sformatf("v%0d", i), vt[i].cnt, vt[i].vld, vt[i].dout, vt[i].ovf, vt[i].unf);
    end

    // Async reset mid-cycle with count = 5, valid_out and underflow both high.
    drive(0, 1, 0, 12'h000);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, DW'(12'h201 + i));
    drive(0, 1, 0, 12'h000);
    check_all("pre_arst", 5, 1, 12'h201, 0, 1);
    bus.read_enable = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("arst", 0, 0, rst_dout, 0, 0);

    // First accepted write on the first rising edge after release.
    @(negedge clk);
    reset = 1'b1;
    bus.write_enable = 1'b1;
    bus.data_in      = 12'h300;
    @(posedge clk);
    #1;
    check_all("post_arst_wr", 1, 0, rst_dout, 0, 0);

    // 20 write/read pairs, pointers wrap twice; each read returns the prior write.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, DW'(12'h301 + i));
      check_all($sformatf("wrap%0d", i), 1, 1, DW'(12'h300 + i), 0, 0);
    end
    drive(0, 1, 0, 12'h000);
    check_all("wrap_last", 0, 1, 12'h314, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
